// File: rtl/blit_line_cache.sv
// Blitter line cache: fully associative, round-robin replacement, one
// outstanding burst refill at a time. Hits return data one cycle after
// acceptance; misses stall the requester until the refill completes.
//
// state | meaning
// IDLE  | serving hits; a miss starts a refill
// REQ   | burst request raised, waiting for mem_ack (beats already accepted)
// FILL  | burst acknowledged, collecting beats until mem_complete
module blit_line_cache #(
   parameter int ADDR_W      = 26,
   parameter int LINES       = 4,
   parameter int BURST_WORDS = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_address,
   input  logic              read_request,
   input  logic [1:0]        read_size,
   output logic [31:0]       read_data,
   output logic              read_stall,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_request,
   input  logic [31:0]       mem_data,
   input  logic              mem_valid,
   input  logic              mem_ack,
   input  logic              mem_complete
);

   localparam int WI_W  = $clog2(BURST_WORDS);
   localparam int OB    = WI_W + 2;
   localparam int TAG_W = ADDR_W - OB;
   localparam int LI_W  = (LINES > 1) ? $clog2(LINES) : 1;

   typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

   state_t            state, state_nxt;
   logic [LINES-1:0]  line_valid;
   logic [TAG_W-1:0]  line_tag  [LINES];
   logic [31:0]       line_data [LINES][BURST_WORDS];
   logic [LI_W-1:0]   rr_ptr, victim, hit_line;
   logic [WI_W-1:0]   beat_ptr;
   logic              flush_seen;
   logic              hit, accept, fill_start, fill_done, beat_en;
   logic [TAG_W-1:0]  req_tag;
   logic [WI_W-1:0]   req_word;
   logic [31:0]       hit_word, lane_data;

   assign req_tag  = read_address[ADDR_W-1:OB];
   assign req_word = read_address[OB-1:2];

   // Tag lookup across all lines; tags are unique so any match is the match.
   always_comb begin
      hit      = 1'b0;
      hit_line = '0;
      for (int i = 0; i < LINES; i++) begin
         if (line_valid[i] && line_tag[i] == req_tag) begin
            hit      = 1'b1;
            hit_line = LI_W'(i);
         end
      end
   end

   // A pending flush blocks acceptance so stale data is never returned.
   assign read_stall  = !reset && read_request && (!hit || flush);
   assign accept      = !reset && read_request && !read_stall;
   assign mem_request = (state == REQ);

   // Byte/halfword/word lane extraction, zero-extended.
   always_comb begin
      hit_word = line_data[hit_line][req_word];
      case (read_size)
         2'b00:   lane_data = {24'b0, hit_word[{read_address[1:0], 3'b000} +: 8]};
         2'b01:   lane_data = {16'b0, hit_word[{read_address[1], 4'b0000} +: 16]};
         default: lane_data = hit_word;
      endcase
   end

   // Refill FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Refill FSM next state; beats count in REQ too since memory may stream before acking.
   always_comb begin
      state_nxt  = state;
      fill_start = 1'b0;
      fill_done  = 1'b0;
      beat_en    = 1'b0;
      case (state)
         IDLE: begin
            if (read_request && !hit) begin
               fill_start = 1'b1;
               state_nxt  = REQ;
            end
         end
         REQ: begin
            beat_en = mem_valid;
            if (mem_complete) begin
               fill_done = 1'b1;
               state_nxt = IDLE;
            end else if (mem_ack) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            beat_en = mem_valid;
            if (mem_complete) begin
               fill_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control registers: valid bits, pointers, burst address, returned data.
   always_ff @(posedge clock) begin
      if (reset) begin
         line_valid  <= '0;
         rr_ptr      <= '0;
         victim      <= '0;
         beat_ptr    <= '0;
         mem_address <= '0;
         read_data   <= '0;
         flush_seen  <= 1'b0;
      end else begin
         if (accept)
            read_data <= lane_data;
         if (fill_start) begin
            victim      <= rr_ptr;
            beat_ptr    <= '0;
            mem_address <= {req_tag, {OB{1'b0}}};
            flush_seen  <= 1'b0;
         end else if (flush) begin
            flush_seen <= 1'b1;
         end
         if (beat_en)
            beat_ptr <= beat_ptr + WI_W'(1);
         if (fill_done)
            rr_ptr <= (rr_ptr == LI_W'(LINES - 1)) ? '0 : rr_ptr + LI_W'(1);
         if (flush) begin
            line_valid <= '0;
         end else begin
            if (fill_start)
               line_valid[rr_ptr] <= 1'b0;
            if (fill_done && !flush_seen)
               line_valid[victim] <= 1'b1;
         end
      end
   end

   // Line storage: beats land in the victim line, tag is written on completion.
   always_ff @(posedge clock) begin
      if (!reset && beat_en)
         line_data[victim][beat_ptr] <= mem_data;
      if (!reset && fill_done)
         line_tag[victim] <= mem_address[ADDR_W-1:OB];
   end

endmodule
